// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared definitions for the ALU operand-fetch / issue stage.
//   - default widths (DW_DEF, AW_DEF, NREG_DEF)
//   - ALU control codes (OP_*), OP_IDLE makes the ALU output 0
//   - ex_pl_t: EX-stage payload {op, rd, x, y} and its empty value EX_IDLE
//   - keeps_carry(): ops whose ALU carry is forwarded to the result port
package alu_issue_pkg;

  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = 3;
  localparam int NREG_DEF = 8;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_INC  = 4'b1000;
  localparam logic [3:0] OP_DEC  = 4'b1001;
  localparam logic [3:0] OP_LT   = 4'b1010;
  localparam logic [3:0] OP_GT   = 4'b1011;
  localparam logic [3:0] OP_EQ   = 4'b1100;
  localparam logic [3:0] OP_IDLE = 4'b1101;

  typedef struct packed {
    logic [3:0]        op;
    logic [AW_DEF-1:0] rd;
    logic [DW_DEF-1:0] x;
    logic [DW_DEF-1:0] y;
  } ex_pl_t;

  localparam ex_pl_t EX_IDLE = '{op: OP_IDLE, rd: '0, x: '0, y: '0};

  function automatic logic keeps_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_issue_rf.sv
// alu_issue_rf: NREG x DW register file.
//   clk, rst_n        : clock, asynchronous active-low reset (clears all entries)
//   we, wa, wd        : synchronous write port
//   ra1/rd1, ra2/rd2  : two asynchronous read ports
module alu_issue_rf
  import alu_issue_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd2
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

endmodule

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: operand-fetch and issue stage in front of an 8-bit
// combinational ALU. Two stages: EX (operands registered, driving the ALU)
// and WB (ALU result captured, written back, offered downstream).
//   in_*      : instruction valid/ready port {op, rd, rs1, rs2, imm_sel, imm}
//   alu_*     : ctrl/x/y to the ALU, out/carry back from it
//   res_*     : result valid/ready port {data, carry, rd}
// Optional macro ALU_ISSUE_BYPASS_EN: forwards alu_out into the operands of an
// instruction accepted while the previous one advances, allowing one
// instruction per cycle. Without it EX must be empty to accept, so the
// register file is always up to date when operands are read.
module alu_issue_seq
  import alu_issue_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic          in_imm_sel,
  input  logic [DW-1:0] in_imm,
  output logic [3:0]    alu_ctrl,
  output logic [DW-1:0] alu_x,
  output logic [DW-1:0] alu_y,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carry,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_carry,
  output logic [AW-1:0] res_rd
);

  ex_pl_t        ex_p0;
  logic          vld_p0;
  logic          vld_p1;
  logic          wb_free;
  logic          ex_adv;
  logic          accept;
  logic [DW-1:0] rf_rd1;
  logic [DW-1:0] rf_rd2;
  logic [DW-1:0] op_x;
  logic [DW-1:0] op_y;

  assign wb_free = !vld_p1 || res_ready;
  assign ex_adv  = vld_p0 && wb_free;
`ifdef ALU_ISSUE_BYPASS_EN
  assign in_ready = !vld_p0 || ex_adv;
`else
  assign in_ready = !vld_p0;
`endif
  assign accept  = in_valid && in_ready;

  alu_issue_rf #(.DW(DW), .NREG(NREG), .AW(AW)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ex_adv),
    .wa    (ex_p0.rd),
    .wd    (alu_out),
    .ra1   (in_rs1),
    .rd1   (rf_rd1),
    .ra2   (in_rs2),
    .rd2   (rf_rd2)
  );

  // Operand selection: the RF write of the advancing instruction lands on the
  // same edge as this accept, so its result is taken straight from the ALU.
  always_comb begin
    op_x = rf_rd1;
    op_y = in_imm_sel ? in_imm : rf_rd2;
`ifdef ALU_ISSUE_BYPASS_EN
    if (ex_adv && (ex_p0.rd == in_rs1)) op_x = alu_out;
    if (ex_adv && !in_imm_sel && (ex_p0.rd == in_rs2)) op_y = alu_out;
`endif
  end

  // ---- fetch -> EX boundary ----
  // An empty EX holds EX_IDLE so the ALU sees OP_IDLE with zero operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      ex_p0  <= EX_IDLE;
    end else if (accept) begin
      vld_p0 <= 1'b1;
      ex_p0  <= '{op: in_op, rd: in_rd, x: op_x, y: op_y};
    end else if (ex_adv) begin
      vld_p0 <= 1'b0;
      ex_p0  <= EX_IDLE;
    end
  end

  assign alu_ctrl = ex_p0.op;
  assign alu_x    = ex_p0.x;
  assign alu_y    = ex_p0.y;

  // ---- EX -> WB boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_rd    <= '0;
    end else if (ex_adv) begin
      vld_p1    <= 1'b1;
      res_data  <= alu_out;
      res_carry <= keeps_carry(ex_p0.op) && alu_carry;
      res_rd    <= ex_p0.rd;
    end else if (res_ready) begin
      vld_p1    <= 1'b0;
    end
  end

  assign res_valid = vld_p1;

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Operand-fetch and issue stage that sits directly upstream of the 8-bit combinational ALU (ctrl/x/y in, out/carry back).
- Holds an 8x8 register file and accepts instructions on a valid/ready handshake.
- Registers ALU operands, captures the ALU result, writes it back to the file and presents it downstream on a valid/ready result port.
- Two-stage pipeline (EX, WB) with write-back forwarding.

Parameters:
- DW, 8, datapath width; must match the ALU (8).
- NREG, 8, register-file entries.
- AW, 3, register index width, equal to log2(NREG).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  instruction accepted when in_valid && in_ready.
- in_op  in  4  ALU ctrl code, passed through unchanged.
- in_rd  in  AW  destination register.
- in_rs1  in  AW  source for ALU x.
- in_rs2  in  AW  source for ALU y.
- in_imm_sel  in  1  1: ALU y = in_imm instead of RF[in_rs2].
- in_imm  in  DW  immediate.
- alu_ctrl  out  4  to ALU ctrl.
- alu_x  out  DW  to ALU x.
- alu_y  out  DW  to ALU y.
- alu_out  in  DW  from ALU out.
- alu_carry  in  1  from ALU carry.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts the result.
- res_data  out  DW  result.
- res_carry  out  1  carry from the ALU for op 0000/0001, otherwise 0.
- res_rd  out  AW  destination register of the result.

Behaviour:
- Reset (async, rst_n=0):
  - All RF entries = 0.
  - ex_valid = 0; wb_valid = 0; res_valid = 0.
  - alu_ctrl = 4'b1101 (ALU output 0); alu_x = alu_y = 0.
  - res_data = 0, res_carry = 0, res_rd = 0.
  - Reset mid-operation discards all in-flight instructions; no RF write occurs.
- Control equations:
  - wb_free = !wb_valid || res_ready.
  - ex_adv = ex_valid && wb_free.
  - in_ready = !ex_valid || ex_adv.
- Accept edge: the EX register loads {op, rd, x, y}. alu_ctrl/alu_x/alu_y are driven directly from the EX register.
  - x = RF[rs1].
  - y = in_imm_sel ? in_imm : RF[rs2].
- Forwarding: when ex_adv is true in the accept cycle and ex_rd equals rs1 (or rs2 with in_imm_sel=0), that operand takes alu_out instead of the RF value.
- ex_adv edge:
  - WB loads res_data=alu_out, res_carry, res_rd=ex_rd, and wb_valid is set.
  - RF[ex_rd] <= alu_out on the same edge.
- ex_valid clears on ex_adv without a new accept.
- wb_valid clears on res_ready without an incoming ex_adv.
- When EX is empty, alu_ctrl returns to 4'b1101 and alu_x/alu_y to 0.
- Latency: accept at edge N puts res_valid high after edge N+1 (2 cycles). Throughput is 1 instruction per cycle when res_ready=1.
- Backpressure (res_valid && !res_ready):
  - res_* hold stable.
  - EX holds, and alu_* hold stable.
  - in_ready = 0 while EX is occupied.
- No register is hardwired. With rs=rd in a single instruction, the old value is read.
- Simultaneous WB drain and EX advance in one cycle is legal and produces no bubble.

Optional Feature:
- Macro: ALU_ISSUE_BYPASS_EN.
- Defined: forwarding from alu_out as described above.
- Undefined:
  - No forwarding path.
  - in_ready = !ex_valid, which gives a one-cycle bubble after every accept.
  - Operands are always read from the RF, which is then already updated.
  - Results stay identical; only throughput differs.

Decomposition:
- Package alu_issue_pkg holds:
  - localparams for the ALU op codes (OP_ADD=0000, OP_SUB=0001, ... OP_EQ=1100, OP_IDLE=1101);
  - the DW and AW defaults;
  - a struct/typedef for the EX-stage payload {op, rd, x, y}.
- One sub-module: alu_issue_rf, the NREG x DW register file with 2 async read ports, 1 sync write port and async reset.

Test Plan:
- Reset, then op=0000, rs1=0, imm_sel=1, imm=0xB5, rd=1 -> res_valid 2 cycles later, res_data=0xB5, res_rd=1.
- Load r2=0x79 the same way, then op=0000 rd=3 rs1=1 rs2=2 -> res_data=0x2E, res_carry equals alu_carry.
- Back-to-back with bypass: r3=r1+r2 immediately followed by op=0101 rd=4 rs1=3 rs2=1 -> in_ready stays 1, second res_data=0x9B (forwarded 0x2E^0xB5). Without the macro -> one-cycle in_ready=0 bubble, same result.
- Backpressure: hold res_ready=0 for 3 cycles with 2 instructions in flight -> res_data, alu_x, alu_y stable; in_ready=0; both results delivered in order after release.
- Op 0010 on r1 (0xB5) and r2 (0x79) -> res_data=0x31, res_carry=0. Op 1100 with rs1=rs2=1 -> res_data=0x01.
- Assert rst_n=0 with EX and WB full -> res_valid=0, alu_ctrl=1101 immediately. Reading r1 afterwards returns 0x00.
